// File: rtl/testmasterslave6_src_pkg.sv
// Shared types for the TestMasterSlave6 source: the model integer type and
// the section enum, burst/drop-counter constants and next-section helper.
package scam_model_types;
    typedef logic signed [31:0] scam_int_t;
endpackage

package testmasterslave6_src_types;
    typedef enum logic {
        section_a = 1'b0,
        section_b = 1'b1
    } Sections;

    localparam int BURST_LEN_DEFAULT = 4;
    localparam int DROP_CNT_W        = 16;

    // Collect until the last sample of a burst is accepted, then emit for one cycle.
    function automatic Sections next_section(input Sections cur, input logic sample, input logic last);
        Sections nxt;
        nxt = section_a;
        if (cur == section_a && sample && last) begin
            nxt = section_b;
        end
        return nxt;
    endfunction
endpackage

// File: rtl/testmasterslave6_src.sv
// Producer end of the TestMasterSlave6 link: sums BURST_LEN samples and emits
// the sum with a one-cycle strobe. Optional drop counter: TESTMASTERSLAVE6_SRC_DROPCNT_EN.
module testmasterslave6_src
    import scam_model_types::*;
    import testmasterslave6_src_types::*;
#(
    parameter int BURST_LEN = BURST_LEN_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic signed [31:0]    m_in,
    input  logic                  m_in_sync,
    output logic signed [31:0]    s_out,
    output logic                  s_out_sync
`ifdef TESTMASTERSLAVE6_SRC_DROPCNT_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_count
`endif
);

    localparam logic [7:0] LAST_CNT = 8'(BURST_LEN - 1);

    Sections   section_signal;
    Sections   nextsection_signal;
    scam_int_t acc_signal;
    logic [7:0] cnt_signal;

    always_comb begin
        nextsection_signal = next_section(section_signal, m_in_sync, cnt_signal == LAST_CNT);
    end

    // Samples arriving during the emit cycle are discarded, never carried into the next burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            section_signal <= section_a;
            acc_signal     <= '0;
            cnt_signal     <= '0;
            s_out          <= '0;
            s_out_sync     <= 1'b0;
`ifdef TESTMASTERSLAVE6_SRC_DROPCNT_EN
            drop_count     <= '0;
`endif
        end else begin
            section_signal <= nextsection_signal;
            s_out_sync     <= 1'b0;
            case (section_signal)
                section_a: begin
                    if (m_in_sync) begin
                        acc_signal <= acc_signal + m_in;
                        cnt_signal <= cnt_signal + 8'd1;
                    end
                end
                section_b: begin
                    s_out      <= acc_signal;
                    s_out_sync <= 1'b1;
                    acc_signal <= '0;
                    cnt_signal <= '0;
`ifdef TESTMASTERSLAVE6_SRC_DROPCNT_EN
                    if (m_in_sync && drop_count != '1) begin
                        drop_count <= drop_count + 1'b1;
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_testmasterslave6_src.sv
// Directed bench for testmasterslave6_src with BURST_LEN = 4; drop-counter
// checks compile in when TESTMASTERSLAVE6_SRC_DROPCNT_EN is defined.
module tb_testmasterslave6_src;
    import testmasterslave6_src_types::*;

    logic               clk;
    logic               rst;
    logic signed [31:0] m_in;
    logic               m_in_sync;
    logic signed [31:0] s_out;
    logic               s_out_sync;
`ifdef TESTMASTERSLAVE6_SRC_DROPCNT_EN
    logic [15:0]        drop_count;
`endif

    int vectorCount = 0;
    int missCount   = 0;

    testmasterslave6_src #(.BURST_LEN(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .m_in       (m_in),
        .m_in_sync  (m_in_sync),
        .s_out      (s_out),
        .s_out_sync (s_out_sync)
`ifdef TESTMASTERSLAVE6_SRC_DROPCNT_EN
        ,
        .drop_count (drop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
        end
    endtask

    // Check outputs left by the edges so far, then drive the next sample.
    task automatic applyStimulus(input string tag, input logic sync, input logic [31:0] data,
                                 input logic expSync, input logic [31:0] expOut);
        @(negedge clk);
        checkOutput({tag, ".sync"}, {31'b0, s_out_sync}, {31'b0, expSync});
        checkOutput({tag, ".out"}, s_out, expOut);
        m_in_sync = sync;
        m_in      = data;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        m_in      = '0;
        m_in_sync = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset.out", s_out, 32'd0);
        checkOutput("reset.sync", {31'b0, s_out_sync}, 32'd0);
        checkOutput("reset.section", 32'(dut.section_signal), 32'(section_a));
`ifdef TESTMASTERSLAVE6_SRC_DROPCNT_EN
        checkOutput("reset.drop", {16'b0, drop_count}, 32'd0);
`endif
        rst = 1'b0;

        // Burst 1,2,3,4: strobe two edges after the last sample.
        applyStimulus("burst0", 1, 32'd1, 0, 32'd0);
        applyStimulus("burst1", 1, 32'd2, 0, 32'd0);
        applyStimulus("burst2", 1, 32'd3, 0, 32'd0);
        applyStimulus("burst3", 1, 32'd4, 0, 32'd0);
        applyStimulus("burst4", 0, 32'd0, 0, 32'd0);
        applyStimulus("burst5", 0, 32'd0, 1, 32'd10);
        applyStimulus("burst6", 0, 32'd0, 0, 32'd10);

        // Gapped, signed samples: -5, 7, -1, 9 sum to 10.
        applyStimulus("gap0", 1, -32'sd5, 0, 32'd10);
        applyStimulus("gap1", 0, 32'd0, 0, 32'd10);
        applyStimulus("gap2", 0, 32'd0, 0, 32'd10);
        applyStimulus("gap3", 0, 32'd0, 0, 32'd10);
        applyStimulus("gap4", 1, 32'd7, 0, 32'd10);
        applyStimulus("gap5", 0, 32'd0, 0, 32'd10);
        applyStimulus("gap6", 1, -32'sd1, 0, 32'd10);
        applyStimulus("gap7", 1, 32'd9, 0, 32'd10);
        applyStimulus("gap8", 0, 32'd0, 0, 32'd10);
        applyStimulus("gap9", 0, 32'd0, 1, 32'd10);
        applyStimulus("gap10", 0, 32'd0, 0, 32'd10);

        // Two's-complement wrap.
        applyStimulus("wrap0", 1, 32'h7FFF_FFFF, 0, 32'd10);
        applyStimulus("wrap1", 1, 32'd1, 0, 32'd10);
        applyStimulus("wrap2", 1, 32'd0, 0, 32'd10);
        applyStimulus("wrap3", 1, 32'd0, 0, 32'd10);
        applyStimulus("wrap4", 0, 32'd0, 0, 32'd10);
        applyStimulus("wrap5", 0, 32'd0, 1, 32'h8000_0000);
        applyStimulus("wrap6", 0, 32'd0, 0, 32'h8000_0000);

        // Continuous ones: the sample in each emit cycle is dropped.
        for (int i = 0; i < 10; i++) begin
            applyStimulus($sformatf("drop%0d", i), 1, 32'd1, (i == 5),
                          (i < 5) ? 32'h8000_0000 : 32'd4);
        end
        applyStimulus("drop10", 0, 32'd0, 1, 32'd4);
        applyStimulus("drop11", 0, 32'd0, 0, 32'd4);
`ifdef TESTMASTERSLAVE6_SRC_DROPCNT_EN
        checkOutput("drop.count", {16'b0, drop_count}, 32'd2);
`endif

        // Reset mid-burst discards the partial sum.
        applyStimulus("mid0", 1, 32'd5, 0, 32'd4);
        applyStimulus("mid1", 1, 32'd5, 0, 32'd4);
        @(negedge clk);
        m_in_sync = 1'b0;
        rst       = 1'b1;
        #1;
        checkOutput("mid.rst.out", s_out, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus("mid2", 1, 32'd1, 0, 32'd0);
        applyStimulus("mid3", 1, 32'd1, 0, 32'd0);
        applyStimulus("mid4", 1, 32'd1, 0, 32'd0);
        applyStimulus("mid5", 1, 32'd1, 0, 32'd0);
        applyStimulus("mid6", 0, 32'd0, 0, 32'd0);

        // Asynchronous reset during the strobe cycle clears outputs at once.
        @(posedge clk);
        #2;
        checkOutput("strobe.sync", {31'b0, s_out_sync}, 32'd1);
        checkOutput("strobe.out", s_out, 32'd4);
        rst = 1'b1;
        #1;
        checkOutput("strobe.rst.sync", {31'b0, s_out_sync}, 32'd0);
        checkOutput("strobe.rst.out", s_out, 32'd0);
`ifdef TESTMASTERSLAVE6_SRC_DROPCNT_EN
        checkOutput("strobe.rst.drop", {16'b0, drop_count}, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        applyStimulus("idle0", 0, 32'd0, 0, 32'd0);
        applyStimulus("idle1", 0, 32'd0, 0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/testmasterslave6_src.md
# testmasterslave6_src

Producer end of the TestMasterSlave6 slave-port link. It accumulates a burst of upstream samples and drives the 32-bit `s_out` value with a one-cycle `s_out_sync` strobe, which is the value/sync pair the TestMasterSlave6 receiver samples. It sits directly upstream of TestMasterSlave6 in the PrintSkeleton test fabric and uses the same section-based state machine style.

## Interface
Parameters:
- `BURST_LEN`, default 4: upstream samples summed per emitted value; legal range 1..255.

Ports:
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `m_in`, input, 32 (integer, signed): upstream sample value.
- `m_in_sync`, input, 1: `m_in` is valid this cycle; there is no backpressure.
- `s_out`, output, 32 (integer, signed): emitted burst sum, registered.
- `s_out_sync`, output, 1: `s_out` is valid; one-cycle strobe, registered.
- `drop_count`, output, 16: count of samples dropped during emit. Present only with `TESTMASTERSLAVE6_SRC_DROPCNT_EN`.

## Operation
- Registers:
  - `section_signal` and `nextsection_signal`, type `Sections`.
  - `acc_signal`, 32-bit signed.
  - `cnt_signal`, 8-bit.
  - `s_out`, `s_out_sync`.
  - `drop_count`, when configured.
- Reset values: `section_a` (both section registers), `acc` = 0, `cnt` = 0, `s_out` = 0, `s_out_sync` = 0, `drop_count` = 0.
- `section_a` (collect): when `m_in_sync` = 1:
  - `acc` ← `acc` + `m_in`, with 32-bit two's-complement wrap and no saturation.
  - `cnt` ← `cnt` + 1.
  - If the old `cnt` = `BURST_LEN`−1, next section is `section_b`.
  - When `m_in_sync` = 0, hold all state.
- `section_b` (emit), always exactly one cycle:
  - `s_out` ← `acc`, `s_out_sync` ← 1.
  - `acc` ← 0, `cnt` ← 0.
  - Next section is `section_a`.
  - `m_in_sync` in this cycle is dropped: not accumulated, not counted toward the next burst. `drop_count` increments when the macro is defined.
- `s_out_sync` is forced to 0 in every cycle other than the one following `section_b`.
- `s_out` holds its last emitted value between strobes.
- `nextsection_signal` carries the next-state value; `section_signal` ← `nextsection_signal` each edge.
- `BURST_LEN` = 1: every sample in `section_a` produces an emit, so the maximum throughput is one value per 2 cycles.

## Timing
- Final sample of a burst is sampled at edge k. `section_b` is active during cycle k→k+1. `s_out`/`s_out_sync` update at edge k+1, and the strobe is high for cycle k+1→k+2.
- Latency from last accepted sample to strobe: 1 cycle, plus the registered output.
- Back-to-back strobes are impossible; there is a minimum of 1 low cycle between strobes.
- Reset mid-burst: the partial `acc` and `cnt` are discarded, and no strobe is emitted.
- Reset asserted during the strobe cycle: `s_out_sync` drops to 0 immediately (asynchronous reset) and `s_out` goes to 0.
- `drop_count` saturates at 0xFFFF; it does not wrap.

## Configuration
- `TESTMASTERSLAVE6_SRC_DROPCNT_EN` defined: the `drop_count` port and register exist and behave as above.
- Undefined: the port and register are absent. Samples arriving in `section_b` are still silently dropped, and all other behaviour is identical.

## Structure
- The `Sections` enum (`section_a`, `section_b`) lives in package `testmasterslave6_src_types`, alongside the `BURST_LEN` default constant and the drop-counter width constant.
- The block imports `scam_model_types::*` and `testmasterslave6_src_types::*`.
- Single module with no sub-module. The accumulate/count datapath is small enough to stay inline with the section state machine.

## Test plan
All scenarios use `BURST_LEN` = 4.
- Reset: assert `rst` for 3 cycles → `s_out` = 0, `s_out_sync` = 0, section is `section_a`, `drop_count` = 0.
- Burst sum: samples 1, 2, 3, 4 on consecutive cycles → one strobe 2 edges after the "4" sample, with `s_out` = 10, then `s_out_sync` = 0.
- Gapped and signed input: samples −5, (idle 3 cycles), 7, (idle), −1, 9 → single strobe, `s_out` = 10; no strobe during idle cycles.
- Wrap: samples 0x7FFFFFFF, 1, 0, 0 → `s_out` = 0x80000000 (−2147483648).
- Drop: continuous `m_in_sync` = 1 with `m_in` = 1 for 10 cycles → strobes of `s_out` = 4 after cycles 4 and 9. The sample in each `section_b` cycle is dropped and `drop_count` = 2 with the macro defined.
- Reset mid-burst: samples 5, 5, then `rst` pulse, then 1, 1, 1, 1 → only one strobe, with `s_out` = 4.
